stack_alu_ext: RTL and testbench

Parametrised stack-machine ALU, successor to the 8-bit add/sub stack ALU. On a start pulse it pops one or two signed operands from the shared operand stack, executes one of eight opcodes, pushes the result back, and updates Z/S/C/V flags. It sits between the control unit (opcode, start, done) and the operand stack (pop/push/data/empty/full).

---
 rtl/stack_alu_pkg.sv | 37 +++
 rtl/stack_alu_exec.sv | 71 +++++++
 rtl/stack_alu_ext.sv | 144 ++++++++++++++
 tb/tb_stack_alu_ext.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/stack_alu_pkg.sv
// Shared definitions for the stack-machine ALU: opcode values, FSM state
// encoding and the unary/binary opcode classifier.
// Optional feature macro: STACK_ALU_MUL_EN (opcode 111 becomes binary MUL
// instead of unary SRA).
package stack_alu_pkg;

   localparam logic [2:0] OP_ADD = 3'b000;
   localparam logic [2:0] OP_SUB = 3'b001;
   localparam logic [2:0] OP_AND = 3'b010;
   localparam logic [2:0] OP_OR  = 3'b011;
   localparam logic [2:0] OP_XOR = 3'b100;
   localparam logic [2:0] OP_NOT = 3'b101;
   localparam logic [2:0] OP_SHL = 3'b110;
   localparam logic [2:0] OP_EXT = 3'b111;   // MUL or SRA depending on build

   typedef enum logic [3:0] {
      ST_IDLE = 4'd0,
      ST_POP1 = 4'd1,
      ST_RCV1 = 4'd2,
      ST_POP2 = 4'd3,
      ST_RCV2 = 4'd4,
      ST_EXEC = 4'd5,
      ST_PUSH = 4'd6,
      ST_DONE = 4'd7,
      ST_ERR  = 4'd8
   } state_t;

   // Unary opcodes consume only the stack top.
   function automatic logic is_unary(input logic [2:0] op);
`ifdef STACK_ALU_MUL_EN
      return (op == OP_NOT) || (op == OP_SHL);
`else
      return (op == OP_NOT) || (op == OP_SHL) || (op == OP_EXT);
`endif
   endfunction

endpackage

// File: rtl/stack_alu_exec.sv
// Combinational datapath of the stack ALU: result plus carry/overflow
// for one opcode applied to op1 (stack top) and op2 (second pop).
// Optional feature macro: STACK_ALU_MUL_EN (opcode 111 = signed MUL,
// otherwise arithmetic shift right by one).
module stack_alu_exec
   import stack_alu_pkg::*;
#(
   parameter int DATA_LEN = 8
) (
   input  logic [2:0]          op,
   input  logic [DATA_LEN-1:0] op1,
   input  logic [DATA_LEN-1:0] op2,
   output logic [DATA_LEN-1:0] result,
   output logic                c_out,
   output logic                v_out
);

   localparam int MSB = DATA_LEN - 1;

   logic [DATA_LEN:0] wide;
`ifdef STACK_ALU_MUL_EN
   logic signed [2*DATA_LEN-1:0] prod;
`endif

   // Opcode decode; carry/borrow comes from the extra bit of the widened sum.
   always_comb begin
      wide   = '0;
      result = '0;
      c_out  = 1'b0;
      v_out  = 1'b0;
`ifdef STACK_ALU_MUL_EN
      prod   = '0;
`endif
      case (op)
         OP_ADD: begin
            wide   = {1'b0, op1} + {1'b0, op2};
            result = wide[MSB:0];
            c_out  = wide[DATA_LEN];
            v_out  = (op1[MSB] == op2[MSB]) && (result[MSB] != op1[MSB]);
         end
         OP_SUB: begin
            // Top bit of the widened difference is set exactly when op1 < op2.
            wide   = {1'b0, op1} - {1'b0, op2};
            result = wide[MSB:0];
            c_out  = wide[DATA_LEN];
            v_out  = (op1[MSB] != op2[MSB]) && (result[MSB] != op1[MSB]);
         end
         OP_AND: result = op1 & op2;
         OP_OR:  result = op1 | op2;
         OP_XOR: result = op1 ^ op2;
         OP_NOT: result = ~op1;
         OP_SHL: begin
            result = {op1[MSB-1:0], 1'b0};
            c_out  = op1[MSB];
         end
         OP_EXT: begin
`ifdef STACK_ALU_MUL_EN
            // Overflow when the full product differs from the sign-extended low half.
            prod   = $signed(op1) * $signed(op2);
            result = prod[MSB:0];
            v_out  = (prod[2*DATA_LEN-1:DATA_LEN] != {DATA_LEN{prod[MSB]}});
`else
            result = {op1[MSB], op1[MSB:1]};
            c_out  = op1[0];
`endif
         end
         default: result = '0;
      endcase
   end

endmodule

// File: rtl/stack_alu_ext.sv
// Stack-machine ALU top: pops one or two operands from the operand stack,
// runs the opcode through stack_alu_exec, pushes the result and updates
// Z/S/C/V. All outputs are registered.
// Optional feature macro: STACK_ALU_MUL_EN (see stack_alu_pkg).
module stack_alu_ext
   import stack_alu_pkg::*;
#(
   parameter int DATA_LEN = 8,
   parameter int OP_LEN   = 3
) (
   input  logic                clk,
   input  logic                rstn,
   input  logic                en,
   input  logic [OP_LEN-1:0]   op,
   output logic                busy,
   output logic                done,
   output logic                err,
   output logic                z_flag,
   output logic                s_flag,
   output logic                c_flag,
   output logic                v_flag,
   output logic                stk_pop,
   output logic                stk_push,
   output logic [DATA_LEN-1:0] stk_data_in,
   input  logic [DATA_LEN-1:0] stk_data_out,
   input  logic                stk_empty,
   input  logic                stk_full
);

   state_t              state_reg;
   logic [2:0]          op_reg;
   logic [DATA_LEN-1:0] op1_reg;
   logic [DATA_LEN-1:0] op2_reg;
   logic [DATA_LEN-1:0] exec_result;
   logic                exec_c;
   logic                exec_v;

   stack_alu_exec #(
      .DATA_LEN (DATA_LEN)
   ) u_exec (
      .op     (op_reg),
      .op1    (op1_reg),
      .op2    (op2_reg),
      .result (exec_result),
      .c_out  (exec_c),
      .v_out  (exec_v)
   );

   // Control FSM with registered strobes. stk_empty/stk_full are sampled on
   // the edge that enters POPx/PUSH, so a suppressed strobe inside that state
   // is itself the record of underflow (POPx) or a full stack (PUSH).
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_reg   <= ST_IDLE;
         op_reg      <= '0;
         op1_reg     <= '0;
         op2_reg     <= '0;
         busy        <= 1'b0;
         done        <= 1'b0;
         err         <= 1'b0;
         z_flag      <= 1'b0;
         s_flag      <= 1'b0;
         c_flag      <= 1'b0;
         v_flag      <= 1'b0;
         stk_pop     <= 1'b0;
         stk_push    <= 1'b0;
         stk_data_in <= '0;
      end else begin
         done        <= 1'b0;
         err         <= 1'b0;
         stk_pop     <= 1'b0;
         stk_push    <= 1'b0;
         stk_data_in <= '0;
         case (state_reg)
            ST_IDLE: begin
               if (en) begin
                  state_reg <= ST_POP1;
                  op_reg    <= op[2:0];
                  busy      <= 1'b1;
                  stk_pop   <= !stk_empty;
               end
            end
            ST_POP1: begin
               if (stk_pop) begin
                  state_reg <= ST_RCV1;
               end else begin
                  state_reg <= ST_ERR;
                  done      <= 1'b1;
                  err       <= 1'b1;
               end
            end
            ST_RCV1: begin
               op1_reg <= stk_data_out;
               if (is_unary(op_reg)) begin
                  state_reg <= ST_EXEC;
               end else begin
                  state_reg <= ST_POP2;
                  stk_pop   <= !stk_empty;
               end
            end
            ST_POP2: begin
               if (stk_pop) begin
                  state_reg <= ST_RCV2;
               end else begin
                  state_reg <= ST_ERR;
                  done      <= 1'b1;
                  err       <= 1'b1;
               end
            end
            ST_RCV2: begin
               op2_reg   <= stk_data_out;
               state_reg <= ST_EXEC;
            end
            ST_EXEC: begin
               state_reg   <= ST_PUSH;
               stk_push    <= !stk_full;
               stk_data_in <= exec_result;
            end
            ST_PUSH: begin
               if (stk_push) begin
                  state_reg <= ST_DONE;
                  done      <= 1'b1;
                  z_flag    <= (exec_result == '0);
                  s_flag    <= exec_result[DATA_LEN-1];
                  c_flag    <= exec_c;
                  v_flag    <= exec_v;
               end else begin
                  stk_push    <= !stk_full;
                  stk_data_in <= exec_result;
               end
            end
            ST_DONE, ST_ERR: begin
               state_reg <= ST_IDLE;
               busy      <= 1'b0;
            end
            default: begin
               state_reg <= ST_IDLE;
               busy      <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_stack_alu_ext.sv
// Randomised scoreboard bench for stack_alu_ext with a behavioural stack
// and arithmetic reference model. Honours STACK_ALU_MUL_EN like the design.
`timescale 1ns/1ps
module tb_stack_alu_ext;

   localparam int W     = 8;
   localparam int DEPTH = 16;
   localparam int MOD   = 1 << W;
   localparam int MAXS  = (1 << (W - 1)) - 1;
   localparam int MINS  = -(1 << (W - 1));
   localparam int HALF  = 5;
`ifdef STACK_ALU_MUL_EN
   localparam bit MUL_EN = 1'b1;
`else
   localparam bit MUL_EN = 1'b0;
`endif

   logic         clk = 1'b0;
   logic         rstn = 1'b0;
   logic         en = 1'b0;
   logic [2:0]   op = 3'd0;
   logic         busy, done, err, z_flag, s_flag, c_flag, v_flag;
   logic         stk_pop, stk_push;
   logic [W-1:0] stk_data_in;
   logic [W-1:0] stk_data_out = '0;
   logic         stk_empty = 1'b1;
   logic         stk_full = 1'b0;
   logic [9+W-1:0] outs;

   stack_alu_ext #(.DATA_LEN(W), .OP_LEN(3)) dut (
      .clk          (clk),
      .rstn         (rstn),
      .en           (en),
      .op           (op),
      .busy         (busy),
      .done         (done),
      .err          (err),
      .z_flag       (z_flag),
      .s_flag       (s_flag),
      .c_flag       (c_flag),
      .v_flag       (v_flag),
      .stk_pop      (stk_pop),
      .stk_push     (stk_push),
      .stk_data_in  (stk_data_in),
      .stk_data_out (stk_data_out),
      .stk_empty    (stk_empty),
      .stk_full     (stk_full)
   );

   always #HALF clk = ~clk;

   assign outs = {busy, done, err, z_flag, s_flag, c_flag, v_flag, stk_pop, stk_push, stk_data_in};

   typedef struct {
      logic [2:0]   op;
      logic         err;
      int           pops;
      int           pushes;
      logic [W-1:0] data;
      logic [3:0]   flags;
      int           lat;
      longint       acc_time;
      int           pop_base;
      int           push_base;
   } exp_t;

   exp_t         sb_q[$];
   logic [W-1:0] stk_q[$];
   logic         force_full = 1'b0;
   int           pop_cnt = 0;
   int           push_cnt = 0;
   logic [W-1:0] last_push = '0;
   logic [3:0]   m_flags = '0;
   int           vectors = 0;
   int           miscompares = 0;

   task automatic check(input string name, input longint act, input longint exp);
      vectors++;
      if (act != exp) begin
         miscompares++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic upd_status();
      stk_empty = (stk_q.size() == 0);
      stk_full  = force_full || (stk_q.size() >= DEPTH);
   endtask

   task automatic clr();
      stk_q.delete();
      upd_status();
   endtask

   task automatic put(input logic [W-1:0] v);
      stk_q.push_back(v);
      upd_status();
   endtask

   // Behavioural stack: reacts to strobes mid-cycle, data valid the next cycle.
   always @(negedge clk) begin
      if (stk_pop && stk_q.size() > 0) begin
         stk_data_out = stk_q.pop_back();
         pop_cnt++;
      end
      if (stk_push) begin
         stk_q.push_back(stk_data_in);
         last_push = stk_data_in;
         push_cnt++;
      end
      upd_status();
   end

   // Reference arithmetic on integer values.
   function automatic void ref_op(input logic [2:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                                  output logic [W-1:0] r, output logic c, output logic v);
      int ua, ub, sa, sb, u, s;
      ua = int'(a);
      ub = int'(b);
      sa = int'($signed(a));
      sb = int'($signed(b));
      c = 1'b0;
      v = 1'b0;
      r = '0;
      case (o)
         3'd0: begin u = ua + ub; s = sa + sb; r = u[W-1:0]; c = (u >= MOD); v = (s > MAXS) || (s < MINS); end
         3'd1: begin u = ua - ub; s = sa - sb; r = u[W-1:0]; c = (ua < ub); v = (s > MAXS) || (s < MINS); end
         3'd2: r = a & b;
         3'd3: r = a | b;
         3'd4: r = a ^ b;
         3'd5: begin u = MOD - 1 - ua; r = u[W-1:0]; end
         3'd6: begin u = ua * 2; r = u[W-1:0]; c = (ua >= MOD / 2); end
         default: begin
`ifdef STACK_ALU_MUL_EN
            s = sa * sb; r = s[W-1:0]; v = (s > MAXS) || (s < MINS);
`else
            s = sa >>> 1; r = s[W-1:0]; c = (ua % 2 == 1);
`endif
         end
      endcase
   endfunction

   // Monitor: every done pulse is matched against the oldest expectation.
   always @(negedge clk) begin
      exp_t e;
      if (rstn && done) begin
         if (sb_q.size() == 0) begin
            check("unexpected_done", 1, 0);
         end else begin
            e = sb_q.pop_front();
            check("err", err, e.err);
            check("latency", (($time - e.acc_time - HALF) / (2 * HALF)) + 1, e.lat);
            check("pops", pop_cnt - e.pop_base, e.pops);
            check("pushes", push_cnt - e.push_base, e.pushes);
            if (!e.err) check("push_data", last_push, e.data);
            check("flags_zscv", {z_flag, s_flag, c_flag, v_flag}, e.flags);
            $display("txn op=%0d err=%0b data=0x%0h flags=%b lat=%0d", e.op, err, last_push, {z_flag, s_flag, c_flag, v_flag}, e.lat);
         end
      end
   end

   // Driver: builds the expectation, launches one operation, waits for done.
   task automatic issue(input logic [2:0] o, input int stall);
      exp_t         e;
      logic [W-1:0] m_stk[$];
      logic [W-1:0] a, b, r, dummy;
      logic         c, v, un, seen;
      int           n, need, ep;
      m_stk = stk_q;
      n = m_stk.size();
      un = (o == 3'd5) || (o == 3'd6) || ((o == 3'd7) && !MUL_EN);
      need = un ? 1 : 2;
      ep = un ? 3 : 5;
      e.op = o;
      e.pop_base = pop_cnt;
      e.push_base = push_cnt;
      e.acc_time = $time + HALF;
      if (n < need) begin
         e.err = 1'b1; e.pops = n; e.pushes = 0; e.data = '0;
         e.lat = (n == 0) ? 2 : 4;
         e.flags = m_flags;
         for (int i = 0; i < n; i++) dummy = m_stk.pop_back();
      end else begin
         a = m_stk.pop_back();
         b = '0;
         if (!un) b = m_stk.pop_back();
         ref_op(o, a, b, r, c, v);
         e.err = 1'b0; e.pops = need; e.pushes = 1; e.data = r;
         e.lat = (un ? 5 : 7) + stall;
         e.flags = {(r == '0), r[W-1], c, v};
         m_flags = e.flags;
         m_stk.push_back(r);
      end
      sb_q.push_back(e);
      force_full = (stall > 0);
      upd_status();
      en = 1'b1;
      op = o;
      @(posedge clk);
      seen = 1'b0;
      for (int i = 0; i < 60; i++) begin
         @(negedge clk);
         if (stall > 0 && i == ep + stall - 1) begin
            force_full = 1'b0;
            upd_status();
         end
         if (done) begin
            seen = 1'b1;
            break;
         end
         en = 1'($urandom_range(0, 1));
         op = 3'($urandom_range(0, 7));
      end
      en = 1'b0;
      force_full = 1'b0;
      if (!seen) begin
         check("done_timeout", 0, 1);
         sb_q.delete();
      end
      stk_q = m_stk;
      upd_status();
      @(negedge clk);
   endtask

   // Reset asserted in cycle 4 of an ADD: no push, no done, everything cleared.
   task automatic reset_abort();
      int pb, ub;
      clr(); put(8'h05); put(8'h03);
      pb = pop_cnt;
      ub = push_cnt;
      en = 1'b1;
      op = 3'd0;
      @(posedge clk);
      @(negedge clk);
      en = 1'b0;
      repeat (3) @(negedge clk);
      rstn = 1'b0;
      #1;
      check("rst_mid_outputs", outs, 0);
      @(negedge clk);
      rstn = 1'b1;
      repeat (4) @(negedge clk);
      check("rst_no_push", push_cnt - ub, 0);
      check("rst_pops_before_abort", pop_cnt - pb, 2);
      check("rst_idle_busy", busy, 0);
      m_flags = '0;
   endtask

   initial begin
      logic [2:0] ro;
      int         rs, nv;
      upd_status();
      repeat (3) @(negedge clk);
      check("reset_outputs", outs, 0);
      rstn = 1'b1;
      @(negedge clk);

      clr(); put(8'h05); put(8'h03); issue(3'd0, 0);        // ADD -> 0x08
      clr(); put(8'h05); put(8'h03); issue(3'd1, 0);        // SUB -> 0xFE
      clr(); put(8'h01); put(8'h7F); issue(3'd0, 0);        // ADD -> 0x80, V
      issue(3'd5, 0);                                        // NOT 0x80 -> 0x7F
      clr(); issue(3'd0, 0);                                 // empty underflow
      clr(); put(8'h22); issue(3'd1, 0);                     // one-element underflow
      clr(); put(8'h40); put(8'h41); issue(3'd4, 3);         // push stalled by full
      reset_abort();
      clr(); put(8'h05); put(8'h03); issue(3'd0, 0);        // normal after reset
`ifdef STACK_ALU_MUL_EN
      clr(); put(8'h10); put(8'h10); issue(3'd7, 0);        // MUL -> 0x00, Z V
`else
      clr(); put(8'h81); issue(3'd7, 0);                     // SRA -> 0xC0, C S
`endif

      for (int t = 0; t < 150; t++) begin
         if (stk_q.size() > 8 || $urandom_range(0, 7) == 0) clr();
         nv = $urandom_range(0, 2);
         for (int k = 0; k < nv; k++) put(W'($urandom));
         ro = 3'($urandom_range(0, 7));
         rs = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0;
         issue(ro, rs);
      end

      repeat (3) @(negedge clk);
      check("scoreboard_drained", sb_q.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
